lzw_dict_ctrl: RTL and testbench

Controller and arbiter for the LZW dictionary held in `single_port_sync_ram` (12-bit address, 64-bit entries, 4096 deep). It owns the RAM's only port and shares it between the encoder's lookup path and its insert path. It allocates new dictionary codes sequentially and clears the dictionary after reset or on command. It sits between the LZW encoder core and the RAM instance.

---
 rtl/lzw_dict_ctrl.sv | 141 ++++++++++++++
 tb/tb_lzw_dict_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_dict_ctrl.sv
// LZW dictionary controller: owns the single RAM port, arbitrates lookups against
// inserts, hands out codes sequentially and sweeps the dictionary to zero on clear.
//
// state   | meaning
// CLEAR   | writing 0 to clr_addr each cycle, FIRST_CODE..DEPTH-1; no grants
// IDLE    | arbitrating lookup vs insert; inserts complete here in one cycle
// RD_WAIT | lookup issued, waiting for ram_valid to forward the read data
module lzw_dict_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4096,
  parameter int FIRST_CODE = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  lu_req,
  input  logic [ADDR_WIDTH-1:0] lu_addr,
  output logic                  lu_gnt,
  output logic                  lu_rvalid,
  output logic [DATA_WIDTH-1:0] lu_rdata,
  input  logic                  ins_req,
  input  logic [DATA_WIDTH-1:0] ins_data,
  output logic                  ins_gnt,
  output logic [ADDR_WIDTH-1:0] ins_code,
  output logic                  dict_full,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_cs,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_valid
);

  typedef enum logic [1:0] {CLEAR, IDLE, RD_WAIT} state_e;

  localparam logic [ADDR_WIDTH-1:0] FIRST_C = ADDR_WIDTH'(FIRST_CODE);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   next_code_q, next_code_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    dict_full_q, dict_full_d;
  logic                    rr_last_q, rr_last_d;
  logic                    lu_elig, ins_elig;

  always_comb begin
    state_d     = state_q;
    next_code_d = next_code_q;
    clr_addr_d  = clr_addr_q;
    dict_full_d = dict_full_q;
    rr_last_d   = rr_last_q;
    lu_elig     = 1'b0;
    ins_elig    = 1'b0;
    lu_gnt      = 1'b0;
    ins_gnt     = 1'b0;
    ins_code    = '0;
    lu_rvalid   = 1'b0;
    lu_rdata    = '0;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;

    // Everything is masked during reset so pre-reset state never reaches the RAM.
    if (!rst) begin
      case (state_q)
        CLEAR: begin
          ram_cs   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = clr_addr_q;
          if (clr_addr_q == LAST_C) begin
            state_d     = IDLE;
            next_code_d = FIRST_C;
            dict_full_d = 1'b0;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
        IDLE: begin
          if (!clear) begin
            lu_elig  = lu_req;
            ins_elig = ins_req && !dict_full_q;
            // rr_last=1 means insert won last, so lookup takes a contended slot.
            lu_gnt   = lu_elig && (!ins_elig || rr_last_q);
            ins_gnt  = ins_elig && (!lu_elig || !rr_last_q);
            if (lu_gnt) begin
              ram_cs    = 1'b1;
              ram_addr  = lu_addr;
              rr_last_d = 1'b0;
              state_d   = RD_WAIT;
            end else if (ins_gnt) begin
              ins_code    = next_code_q;
              ram_cs      = 1'b1;
              ram_we      = 1'b1;
              ram_addr    = next_code_q;
              ram_data_in = ins_data;
              rr_last_d   = 1'b1;
              if (next_code_q == LAST_C) dict_full_d = 1'b1;
              else                       next_code_d = next_code_q + 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (ram_valid && !clear) begin
            lu_rvalid = 1'b1;
            lu_rdata  = ram_data_out;
            state_d   = IDLE;
          end
        end
        default: state_d = CLEAR;
      endcase

      if (clear) begin
        state_d    = CLEAR;
        clr_addr_d = FIRST_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      next_code_q <= FIRST_C;
      clr_addr_q  <= FIRST_C;
      dict_full_q <= 1'b0;
      rr_last_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      next_code_q <= next_code_d;
      clr_addr_q  <= clr_addr_d;
      dict_full_q <= dict_full_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign busy      = rst || (state_q == CLEAR);
  assign dict_full = dict_full_q;

endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// Bench for lzw_dict_ctrl with a behavioural single-port RAM, a reference copy of
// the dictionary and a queue of expected lookup data.
module tb_lzw_dict_ctrl;

  localparam int AW = 12;
  localparam int DW = 64;
  localparam int DEPTH = 4096;
  localparam int FIRST = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          busy;
  logic          lu_req = 1'b0;
  logic [AW-1:0] lu_addr = '0;
  logic          lu_gnt, lu_rvalid;
  logic [DW-1:0] lu_rdata;
  logic          ins_req = 1'b0;
  logic [DW-1:0] ins_data = '0;
  logic          ins_gnt;
  logic [AW-1:0] ins_code;
  logic          dict_full;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_cs, ram_we;
  logic [DW-1:0] ram_data_out = '0;
  logic          ram_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int            model_next;
  logic [DW-1:0] sb_q [$];

  lzw_dict_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .FIRST_CODE(FIRST)) dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy),
    .lu_req(lu_req), .lu_addr(lu_addr), .lu_gnt(lu_gnt), .lu_rvalid(lu_rvalid), .lu_rdata(lu_rdata),
    .ins_req(ins_req), .ins_data(ins_data), .ins_gnt(ins_gnt), .ins_code(ins_code),
    .dict_full(dict_full), .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_cs(ram_cs),
    .ram_we(ram_we), .ram_data_out(ram_data_out), .ram_valid(ram_valid)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data_in;
    if (ram_cs && !ram_we) ram_data_out <= ram_mem[ram_addr];
    ram_valid <= ram_cs && !ram_we;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (lu_rvalid) begin
      if (sb_q.size() == 0) chk("rvalid_unexpected", lu_rvalid, 1'b0);
      else chk("lu_rdata", lu_rdata, sb_q.pop_front());
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Enters on the first sweep cycle; requests are held to prove nothing is granted.
  task automatic sweep_check(input string tag);
    int errs = 0;
    lu_req = 1'b1;
    ins_req = 1'b1;
    for (int i = 0; i < DEPTH - FIRST; i++) begin
      @(negedge clk);
      if (!(ram_cs && ram_we && ram_addr == AW'(FIRST + i) && ram_data_in == '0 && busy
            && !lu_gnt && !ins_gnt && !lu_rvalid)) errs++;
      next_cycle();
    end
    lu_req = 1'b0;
    ins_req = 1'b0;
    chk({tag, "_seq_errs"}, errs, 0);
    @(negedge clk);
    chk({tag, "_busy_fall"}, busy, 1'b0);
    chk({tag, "_idle_cs"}, ram_cs, 1'b0);
    next_cycle();
    for (int i = FIRST; i < DEPTH; i++) ref_mem[i] = '0;
    model_next = FIRST;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear = 1'b0;
    lu_req = 1'b1;
    ins_req = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst_busy", busy, 1'b1);
    chk("rst_cs", ram_cs, 1'b0);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_lu_gnt", lu_gnt, 1'b0);
    chk("rst_ins_gnt", ins_gnt, 1'b0);
    chk("rst_rvalid", lu_rvalid, 1'b0);
    chk("rst_full", dict_full, 1'b0);
    chk("rst_ins_code", ins_code, 0);
    next_cycle();
    rst = 1'b0;
    sweep_check("reset_sweep");
  endtask

  task automatic do_insert(input logic [DW-1:0] data);
    logic got = 1'b0;
    ins_req = 1'b1;
    ins_data = data;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (ins_gnt) begin
        got = 1'b1;
        chk("ins_code", ins_code, AW'(model_next));
        chk("ins_ram_we", {ram_cs, ram_we}, 2'b11);
        chk("ins_ram_addr", ram_addr, AW'(model_next));
        chk("ins_ram_data", ram_data_in, data);
        ref_mem[model_next] = data;
        model_next++;
      end
      next_cycle();
    end
    ins_req = 1'b0;
    chk("ins_gnt_seen", got, 1'b1);
  endtask

  task automatic do_lookup(input logic [AW-1:0] addr);
    logic got = 1'b0;
    lu_req = 1'b1;
    lu_addr = addr;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (lu_gnt) begin
        got = 1'b1;
        chk("lu_ram_rd", {ram_cs, ram_we}, 2'b10);
        chk("lu_ram_addr", ram_addr, addr);
        sb_q.push_back(ref_mem[addr]);
      end
      next_cycle();
    end
    lu_req = 1'b0;
    chk("lu_gnt_seen", got, 1'b1);
    @(negedge clk);
    chk("lu_rvalid_next", lu_rvalid, 1'b1);
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pat [6] = '{1, 0, 2, 1, 0, 2};
    int errs;
    model_next = FIRST;

    reset_dut();

    do_insert(64'hABCD_E123);
    do_lookup(AW'(256));

    reset_dut();
    lu_req = 1'b1;
    ins_req = 1'b1;
    lu_addr = AW'(256);
    for (int c = 0; c < 6; c++) begin
      ins_data = 64'h5A5A_0000 + 64'(c);
      @(negedge clk);
      chk($sformatf("ct_lu_gnt%0d", c), lu_gnt, exp_pat[c] == 1);
      chk($sformatf("ct_ins_gnt%0d", c), ins_gnt, exp_pat[c] == 2);
      if (lu_gnt) sb_q.push_back(ref_mem[256]);
      if (ins_gnt) begin
        chk($sformatf("ct_code%0d", c), ins_code, AW'(model_next));
        ref_mem[model_next] = ins_data;
        model_next++;
      end
      next_cycle();
    end
    lu_req = 1'b0;
    ins_req = 1'b0;

    errs = 0;
    ins_req = 1'b1;
    while (model_next < DEPTH) begin
      ins_data = {32'hF111_0000, 20'd0, AW'(model_next)};
      @(negedge clk);
      if (!(ins_gnt && ins_code == AW'(model_next) && ram_we && ram_addr == AW'(model_next)
            && ram_data_in == ins_data)) errs++;
      if (model_next == DEPTH - 1) chk("fill_full_before_last", dict_full, 1'b0);
      ref_mem[model_next] = ins_data;
      model_next++;
      next_cycle();
    end
    chk("fill_errs", errs, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_flag", dict_full, 1'b1);
      chk("full_no_gnt", ins_gnt, 1'b0);
      chk("full_no_ram", ram_cs, 1'b0);
      next_cycle();
    end
    ins_req = 1'b0;
    do_lookup(AW'(4095));
    do_lookup(AW'(300));

    lu_req = 1'b1;
    lu_addr = AW'(300);
    @(negedge clk);
    chk("cmr_lu_gnt", lu_gnt, 1'b1);
    if (lu_gnt) sb_q.push_back(ref_mem[300]);
    next_cycle();
    lu_req = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    chk("cmr_rvalid", lu_rvalid, 1'b0);
    next_cycle();
    clear = 1'b0;
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    sweep_check("clear_sweep");
    chk("cmr_full_cleared", dict_full, 1'b0);
    do_insert(64'h0000_1234_5678_9ABC);

    clear = 1'b1;
    lu_req = 1'b1;
    ins_req = 1'b1;
    lu_addr = AW'(256);
    ins_data = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("cvr_lu_gnt", lu_gnt, 1'b0);
    chk("cvr_ins_gnt", ins_gnt, 1'b0);
    chk("cvr_ram_cs", ram_cs, 1'b0);
    next_cycle();
    clear = 1'b0;
    sweep_check("req_clear_sweep");
    do_lookup(AW'(256));

    repeat (2) next_cycle();
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
